hidden_layer_accumulator: RTL and testbench
===========================================

Name: hidden_layer_accumulator

Overview:
- Downstream consumer of the input index queue.
- Drains the buffered queue of active-pixel indices with a dequeue pulse handshake.
- For each index, fetches one weight word holding the weights of all hidden nodes at that input index, and adds every lane into a per-node signed saturating accumulator.
- Binary input pixels make each hidden-node pre-activation the sum of the weights at the active indices, so no multiplier is needed. The sums feed the activation stage.

Parameters:
- HIDDEN_NODES, 15, number of parallel hidden-node accumulators.
- WEIGHT_WIDTH, 8, signed weight width per node lane.
- ACC_WIDTH, 16, signed accumulator width per node (must be > WEIGHT_WIDTH).
- INPUT_NODES, 784, valid index range 0..INPUT_NODES-1 (matches `INPUT_LAYER_NODES).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetN  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins draining the queue. Ignored unless idle or done.
- queueEmpty  input  1  from queue; high when no entries remain.
- indexOut  input  10  from queue; index fetched by the last dequeue.
- dequeue  output  1  pulse to queue; high exactly one clk cycle per fetch.
- weightAddr  output  10  weight memory address (registered).
- weightData  input  HIDDEN_NODES*WEIGHT_WIDTH  weight word; lane n at bits [n*WEIGHT_WIDTH +: WEIGHT_WIDTH]. Valid one cycle after weightAddr changes (synchronous ROM).
- sumsOut  output  HIDDEN_NODES*ACC_WIDTH  accumulators; lane n at [n*ACC_WIDTH +: ACC_WIDTH].
- sumsValid  output  1  high while done; sumsOut stable.
- busy  output  1  high from the cycle after start until done.
- activeCount  output  10  number of indices accumulated this pass.
- rangeError  output  1  sticky; set when an index ≥ INPUT_NODES was fetched.

Behaviour:
- Reset (resetN low, async): state IDLE, dequeue=0, weightAddr=0, all accumulators=0, sumsValid=0, busy=0, activeCount=0, rangeError=0. Reset mid-pass aborts immediately. dequeue must drop in the same reset assertion.
- States: IDLE, CHECK, DEQ_HI, DEQ_LO, ADDR, READ, ACCUM, DONE.
- IDLE/DONE: on start, clear accumulators, activeCount and rangeError; clear sumsValid; go to CHECK. busy=1.
- CHECK: queueEmpty=1 → DONE; else → DEQ_HI.
- DEQ_HI: dequeue=1 for one cycle. The queue latches indexOut on this rising edge. → DEQ_LO.
- DEQ_LO: dequeue=0. The queue advances its front pointer and queueEmpty settles. → ADDR.
- ADDR: sample indexOut.
  - If indexOut ≥ INPUT_NODES: set rangeError, skip accumulation, → CHECK.
  - Else: weightAddr<=indexOut, → READ.
- READ: wait one cycle for ROM data. → ACCUM.
- ACCUM: for every lane n, acc[n] <= sat(acc[n] + sign_extend(weight lane n)); activeCount+1. → CHECK.
- Per-entry cost: 6 cycles (CHECK..ACCUM). Start→sumsValid latency: 2 + 6*K cycles for K valid entries.
- The last valid entry raises queueEmpty after its own dequeue. It is still accumulated; the following CHECK terminates.
- Saturation: the sum is computed at ACC_WIDTH+1 bits.
  - Above 2^(ACC_WIDTH-1)-1 → clamp to max.
  - Below -2^(ACC_WIDTH-1) → clamp to min.
  - Per lane, independent.
- DONE: sumsValid=1, busy=0; sumsOut, activeCount and rangeError hold until the next start or reset.
- start while busy: ignored, no effect on the pass.
- start and queueEmpty=1 at start: the next cycle is CHECK → DONE, sums=0, activeCount=0.
- activeCount wraps at 1024. This cannot occur with INPUT_NODES ≤ 784 and one pass per buffer.
- sumsOut is driven directly from the accumulator registers. Values change only in ACCUM or on clear.

Test Plan:
- Params HIDDEN_NODES=2, WEIGHT_WIDTH=8, ACC_WIDTH=16 for all scenarios below.
- Empty queue: queueEmpty=1, pulse start → sumsValid=1 two cycles later, sums {0,0}, activeCount=0, dequeue never asserted.
- Three entries {3,10,500}, ROM lane0=+5, lane1=-2 at each → exactly three one-cycle dequeue pulses, weightAddr sequence 3,10,500, sums {15,-6}, activeCount=3, sumsValid 20 cycles after start.
- Saturation: 300 entries, lane0=+127, lane1=-128 → lane0 clamps at 32767, lane1 = -38400 clamps at -32768.
- Out-of-range index 900 between indices 1 and 2 → rangeError=1, activeCount=2, only indices 1 and 2 summed, no ROM access at 900.
- Async reset mid-ACCUM → all outputs zero immediately, dequeue=0. A new start after release runs a clean pass with correct sums.
- start pulsed again while busy → ignored; result identical to the single-start run.

Source files
------------

// File: rtl/hidden_layer_accumulator_if.sv
// Bus between the hidden-layer accumulator and its two neighbours:
// the input index queue (dequeue handshake) and the weight ROM (address/data).
interface hidden_layer_accumulator_if #(
  parameter int HIDDEN_NODES = 15,
  parameter int WEIGHT_WIDTH = 8
);
  logic                                 queueEmpty;
  logic [9:0]                           indexOut;
  logic                                 dequeue;
  logic [9:0]                           weightAddr;
  logic [HIDDEN_NODES*WEIGHT_WIDTH-1:0] weightData;

  // The accumulator masters both the queue and the ROM.
  modport master (
    output dequeue,
    output weightAddr,
    input  queueEmpty,
    input  indexOut,
    input  weightData
  );

  modport slave (
    input  dequeue,
    input  weightAddr,
    output queueEmpty,
    output indexOut,
    output weightData
  );
endinterface

// File: rtl/hidden_layer_accumulator.sv
// Drains the active-pixel index queue and sums the weight lanes at each index
// into per-hidden-node signed saturating accumulators (binary inputs, no multiplier).
module hidden_layer_accumulator #(
  parameter int HIDDEN_NODES = 15,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int INPUT_NODES  = 784
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              start,
  hidden_layer_accumulator_if.master        queueRom,
  output logic [HIDDEN_NODES*ACC_WIDTH-1:0] sumsOut,
  output logic                              sumsValid,
  output logic                              busy,
  output logic [9:0]                        activeCount,
  output logic                              rangeError
);

  typedef enum logic [2:0] {
    IDLE, CHECK, DEQ_HI, DEQ_LO, ADDR, READ, ACCUM, DONE
  } stateT;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX     = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN     = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [10:0]          INPUT_LIMIT = 11'(INPUT_NODES);

  stateT                state;
  stateT                nextState;
  logic                 startPass;
  logic                 indexInRange;
  logic [ACC_WIDTH-1:0] acc [HIDDEN_NODES];

  // Sum at ACC_WIDTH+1 bits; disagreeing top two bits mean the true sum left
  // the ACC_WIDTH range, and the top bit tells which rail to clamp to.
  function automatic logic [ACC_WIDTH-1:0] satAdd(
    input logic [ACC_WIDTH-1:0]    accValue,
    input logic [WEIGHT_WIDTH-1:0] weight
  );
    logic [ACC_WIDTH:0] wide;
    wide = {accValue[ACC_WIDTH-1], accValue}
         + {{(ACC_WIDTH+1-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
    if (wide[ACC_WIDTH] == wide[ACC_WIDTH-1]) begin
      return wide[ACC_WIDTH-1:0];
    end else if (wide[ACC_WIDTH]) begin
      return ACC_MIN;
    end else begin
      return ACC_MAX;
    end
  endfunction

  assign indexInRange = ({1'b0, queueRom.indexOut} < INPUT_LIMIT);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    nextState         = state;
    queueRom.dequeue  = 1'b0;
    busy              = 1'b0;
    sumsValid         = 1'b0;
    startPass         = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        sumsValid = (state == DONE);
        if (start) begin
          startPass = 1'b1;
          nextState = CHECK;
        end
      end
      CHECK: begin
        busy      = 1'b1;
        nextState = queueRom.queueEmpty ? DONE : DEQ_HI;
      end
      DEQ_HI: begin
        busy             = 1'b1;
        queueRom.dequeue = 1'b1;
        nextState        = DEQ_LO;
      end
      DEQ_LO: begin
        busy      = 1'b1;
        nextState = ADDR;
      end
      ADDR: begin
        busy      = 1'b1;
        nextState = indexInRange ? READ : CHECK;
      end
      READ: begin
        busy      = 1'b1;
        nextState = ACCUM;
      end
      ACCUM: begin
        busy      = 1'b1;
        nextState = CHECK;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: the accumulator array is a bank of flops, not a RAM, and must read
  // zero straight out of reset, so it is reset like any other register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      queueRom.weightAddr <= '0;
      activeCount         <= '0;
      rangeError          <= 1'b0;
      for (int n = 0; n < HIDDEN_NODES; n++) begin
        acc[n] <= '0;
      end
    end else if (startPass) begin
      activeCount <= '0;
      rangeError  <= 1'b0;
      for (int n = 0; n < HIDDEN_NODES; n++) begin
        acc[n] <= '0;
      end
    end else begin
      case (state)
        ADDR: begin
          // Out-of-range indices never reach the ROM address bus.
          if (indexInRange) begin
            queueRom.weightAddr <= queueRom.indexOut;
          end else begin
            rangeError <= 1'b1;
          end
        end
        ACCUM: begin
          activeCount <= activeCount + 10'd1;
          for (int n = 0; n < HIDDEN_NODES; n++) begin
            acc[n] <= satAdd(acc[n], queueRom.weightData[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar n = 0; n < HIDDEN_NODES; n++) begin : g_sums
    assign sumsOut[n*ACC_WIDTH +: ACC_WIDTH] = acc[n];
  end

endmodule

// File: tb/tb_hidden_layer_accumulator.sv
// Self-checking bench: a behavioural index queue and weight ROM drive the DUT,
// and every pass is compared against an arithmetic reference model.
module tb_hidden_layer_accumulator;

  localparam int HN     = 2;
  localparam int WW     = 8;
  localparam int AW     = 16;
  localparam int IN     = 784;
  localparam int SATMAX = 32767;
  localparam int SATMIN = -32768;

  logic          clk    = 1'b0;
  logic          resetN = 1'b0;
  logic          start  = 1'b0;
  logic [HN*AW-1:0] sumsOut;
  logic          sumsValid;
  logic          busy;
  logic [9:0]    activeCount;
  logic          rangeError;

  hidden_layer_accumulator_if #(.HIDDEN_NODES(HN), .WEIGHT_WIDTH(WW)) queueRom ();

  hidden_layer_accumulator #(
    .HIDDEN_NODES(HN), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .INPUT_NODES(IN)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .queueRom   (queueRom),
    .sumsOut    (sumsOut),
    .sumsValid  (sumsValid),
    .busy       (busy),
    .activeCount(activeCount),
    .rangeError (rangeError)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural queue and ROM ----------------
  int   qMem [1024];
  int   qLength = 0;
  int   readPtr;
  logic qLoad = 1'b0;
  int   rom [HN][1024];

  assign queueRom.queueEmpty = (readPtr >= qLength);

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      readPtr           <= 0;
      queueRom.indexOut <= '0;
    end else if (qLoad) begin
      readPtr <= 0;
    end else if (queueRom.dequeue) begin
      queueRom.indexOut <= 10'(qMem[readPtr]);
      readPtr           <= readPtr + 1;
    end
  end

  always @(posedge clk) begin
    for (int n = 0; n < HN; n++) begin
      queueRom.weightData[n*WW +: WW] <= WW'(rom[n][queueRom.weightAddr]);
    end
  end

  // ---------------- bus monitor ----------------
  int         deqCount;
  int         deqWide;
  int         maxAddr;
  int         addrLog [$];
  logic       prevDeq;
  logic [9:0] lastAddr;

  always @(negedge clk) begin
    if (qLoad) begin
      deqCount = 0;
      deqWide  = 0;
      maxAddr  = 0;
      prevDeq  = 1'b0;
      lastAddr = queueRom.weightAddr;
      addrLog.delete();
    end else begin
      if (queueRom.dequeue) deqCount++;
      if (queueRom.dequeue && prevDeq) deqWide++;
      prevDeq = queueRom.dequeue;
      if (queueRom.weightAddr != lastAddr) addrLog.push_back(int'(queueRom.weightAddr));
      lastAddr = queueRom.weightAddr;
      if (int'(queueRom.weightAddr) > maxAddr) maxAddr = int'(queueRom.weightAddr);
    end
  end

  // ---------------- checking ----------------
  int compared   = 0;
  int mismatched = 0;

  task automatic checkValue(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int laneSum(input int n);
    return int'($signed(sumsOut[n*AW +: AW]));
  endfunction

  // ---------------- reference model ----------------
  int expSum [HN];
  int expCount;
  int expErr;
  int expLatency;

  task automatic buildModel();
    int invalid;
    int s;
    invalid  = 0;
    expCount = 0;
    expErr   = 0;
    for (int n = 0; n < HN; n++) expSum[n] = 0;
    for (int i = 0; i < qLength; i++) begin
      if (qMem[i] >= IN) begin
        expErr = 1;
        invalid++;
      end else begin
        expCount++;
        for (int n = 0; n < HN; n++) begin
          s = expSum[n] + rom[n][qMem[i]];
          if (s > SATMAX) s = SATMAX;
          if (s < SATMIN) s = SATMIN;
          expSum[n] = s;
        end
      end
    end
    // Each accepted entry costs six cycles, a rejected one four (no READ/ACCUM).
    expLatency = 2 + 6 * expCount + 4 * invalid;
  endtask

  task automatic loadQueue();
    @(posedge clk); #1 qLoad = 1'b1;
    @(posedge clk); #1 qLoad = 1'b0;
  endtask

  task automatic randomRom(input int lo, input int hi);
    for (int n = 0; n < HN; n++)
      for (int a = 0; a < 1024; a++)
        rom[n][a] = int'($urandom_range(hi - lo, 0)) + lo;
  endtask

  task automatic runPass(input string tag, input bit extraStarts);
    int cycles;
    buildModel();
    loadQueue();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cycles = 1;
    checkValue($sformatf("%s busy", tag), int'(busy), 1);
    while (!sumsValid && cycles < expLatency + 50) begin
      if (extraStarts && (cycles == 3 || cycles == expLatency / 2) && cycles < expLatency - 1)
        start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cycles++;
    end
    checkValue($sformatf("%s sumsValid", tag), int'(sumsValid), 1);
    checkValue($sformatf("%s latency", tag), cycles, expLatency);
    checkValue($sformatf("%s busyDone", tag), int'(busy), 0);
    for (int n = 0; n < HN; n++)
      checkValue($sformatf("%s lane%0d", tag, n), laneSum(n), expSum[n]);
    checkValue($sformatf("%s activeCount", tag), int'(activeCount), expCount);
    checkValue($sformatf("%s rangeError", tag), int'(rangeError), expErr);
    checkValue($sformatf("%s dequeues", tag), deqCount, qLength);
    checkValue($sformatf("%s wideDequeue", tag), deqWide, 0);
    checkValue($sformatf("%s addrInRange", tag), int'(maxAddr < IN), 1);
    repeat (3) @(posedge clk);
    #1;
    checkValue($sformatf("%s holdValid", tag), int'(sumsValid), 1);
    checkValue($sformatf("%s holdLane0", tag), laneSum(0), expSum[0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hits;
    int guard;

    for (int n = 0; n < HN; n++)
      for (int a = 0; a < 1024; a++) rom[n][a] = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset sumsValid", int'(sumsValid), 0);
    checkValue("reset busy", int'(busy), 0);
    checkValue("reset activeCount", int'(activeCount), 0);
    checkValue("reset rangeError", int'(rangeError), 0);
    checkValue("reset dequeue", int'(queueRom.dequeue), 0);
    checkValue("reset weightAddr", int'(queueRom.weightAddr), 0);
    checkValue("reset lane0", laneSum(0), 0);
    checkValue("reset lane1", laneSum(1), 0);
    resetN = 1'b1;

    // Empty queue
    qLength = 0;
    runPass("empty", 1'b0);

    // Three entries, lane0 +5, lane1 -2
    foreach (qMem[i]) qMem[i] = 0;
    qMem[0] = 3; qMem[1] = 10; qMem[2] = 500; qLength = 3;
    for (int i = 0; i < 3; i++) begin
      rom[0][qMem[i]] = 5;
      rom[1][qMem[i]] = -2;
    end
    runPass("three", 1'b0);
    checkValue("three lane0Const", laneSum(0), 15);
    checkValue("three lane1Const", laneSum(1), -6);
    checkValue("three addrCount", addrLog.size(), 3);
    if (addrLog.size() == 3) begin
      checkValue("three addr0", addrLog[0], 3);
      checkValue("three addr1", addrLog[1], 10);
      checkValue("three addr2", addrLog[2], 500);
    end

    // Saturation: 300 entries, both lanes hit their rail
    for (int a = 0; a < 1024; a++) begin
      rom[0][a] = 127;
      rom[1][a] = -128;
    end
    for (int i = 0; i < 300; i++) qMem[i] = i;
    qLength = 300;
    runPass("saturate", 1'b0);
    checkValue("saturate lane0Max", laneSum(0), SATMAX);
    checkValue("saturate lane1Min", laneSum(1), SATMIN);

    // Out-of-range index between two valid ones
    randomRom(-128, 127);
    rom[0][1] = 11;  rom[1][1] = -7;
    rom[0][2] = 20;  rom[1][2] = 3;
    rom[0][900] = 77; rom[1][900] = 77;
    qMem[0] = 1; qMem[1] = 900; qMem[2] = 2; qLength = 3;
    runPass("range", 1'b0);
    checkValue("range lane0Const", laneSum(0), 31);
    checkValue("range count", int'(activeCount), 2);
    checkValue("range addrCount", addrLog.size(), 2);
    if (addrLog.size() == 2) begin
      checkValue("range addr0", addrLog[0], 1);
      checkValue("range addr1", addrLog[1], 2);
    end

    // Async reset while in ACCUM of the third entry
    randomRom(-128, 127);
    for (int i = 0; i < 50; i++) qMem[i] = int'($urandom_range(IN - 1, 0));
    qLength = 50;
    loadQueue();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    hits  = 0;
    guard = 0;
    while (hits < 3 && guard < 200) begin
      @(posedge clk); #1;
      if (queueRom.dequeue) hits++;
      guard++;
    end
    checkValue("midReset reachedDequeue", hits, 3);
    repeat (4) @(posedge clk);
    #1 resetN = 1'b0;
    #1;
    checkValue("midReset dequeue", int'(queueRom.dequeue), 0);
    checkValue("midReset sumsValid", int'(sumsValid), 0);
    checkValue("midReset busy", int'(busy), 0);
    checkValue("midReset activeCount", int'(activeCount), 0);
    checkValue("midReset rangeError", int'(rangeError), 0);
    checkValue("midReset weightAddr", int'(queueRom.weightAddr), 0);
    checkValue("midReset lane0", laneSum(0), 0);
    checkValue("midReset lane1", laneSum(1), 0);
    @(posedge clk); #1 resetN = 1'b1;
    for (int i = 0; i < 20; i++) qMem[i] = int'($urandom_range(IN - 1, 0));
    qLength = 20;
    runPass("afterReset", 1'b0);

    // start pulsed again while busy must not disturb the pass
    randomRom(-128, 127);
    for (int i = 0; i < 40; i++) qMem[i] = int'($urandom_range(IN - 1, 0));
    qLength = 40;
    runPass("restart", 1'b1);

    // Randomised passes; odd passes bias weights positive to reach the rail
    for (int p = 0; p < 4; p++) begin
      if (p % 2 == 1) randomRom(60, 127);
      else            randomRom(-128, 127);
      qLength = int'($urandom_range(400, 0));
      for (int i = 0; i < qLength; i++) begin
        if ($urandom_range(19, 0) == 0) qMem[i] = int'($urandom_range(1023, IN));
        else                            qMem[i] = int'($urandom_range(IN - 1, 0));
      end
      runPass($sformatf("random%0d", p), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
